bcd_entry: RTL and testbench
============================

Name: bcd_entry

Overview:
User-input counterpart to the multiplexed BCD 7-segment display driver. Three raw pushbuttons (increment digit, select digit, enter) are debounced and build a 3-digit decimal number. On enter, the block converts the BCD number to an 8-bit binary value with an iterative reverse double-dabble, then presents it with a one-cycle valid pulse. Its typical use is loading a PC address. Its `bcd`/`digit_sel` outputs feed the display so the user sees the digits being entered.

Parameters:
DEBOUNCE_CYCLES, 100_000, number of stable cycles required before a button change is accepted (1 ms at 100 MHz)
CNT_W, 17, width of the debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES

Ports:
clk  input  1  system clock, 100 MHz
rst  input  1  synchronous, active-high reset
btn_inc  input  1  raw asynchronous button; increments the selected digit
btn_sel  input  1  raw asynchronous button; rotates the digit selection
btn_enter  input  1  raw asynchronous button; starts conversion
bcd  output  12  entered digits {hundreds, tens, ones}, 4 bits each
digit_sel  output  2  selected digit: 0 = ones, 1 = tens, 2 = hundreds
value  output  8  last successfully converted binary value
value_valid  output  1  one-cycle pulse when `value` updates
overflow  output  1  sticky flag: last conversion result was greater than 255
busy  output  1  high while in CONVERT

Behaviour:
- Reset (synchronous, active-high): all outputs 0; state = IDLE; debounce counters and stable levels = 0. A reset mid-conversion aborts it; no `value_valid` follows.
- Debounce, per button:
  - 2-FF synchronizer feeds the stable-level logic.
  - If synced != stable: the counter increments. When it reaches DEBOUNCE_CYCLES-1, stable <= synced and counter <= 0.
  - If synced == stable: counter <= 0.
  - A rising edge of stable produces a one-cycle event. Falling edges produce nothing.
- State machine IDLE -> CONVERT -> DONE -> IDLE.
- IDLE, event priority: enter > sel > inc. Lower-priority events in the same cycle are dropped.
  - inc: `bcd` nibble at `digit_sel` increments; 9 -> 0 wrap; other nibbles unchanged.
  - sel: `digit_sel` 0 -> 1 -> 2 -> 0. The value 3 never occurs.
  - enter: load a 22-bit shift register {bcd[11:0], 10'b0}; iteration counter = 0; go to CONVERT; `busy` = 1 from the next cycle.
- CONVERT: 10 iterations, one per cycle. Each iteration:
  - Shift the register right by 1.
  - Then, for each BCD nibble independently, if nibble >= 8, subtract 3.
  - After iteration 10, bits [9:0] hold the binary result; go to DONE.
- DONE (one cycle):
  - If result <= 255: `value` <= result[7:0], `value_valid` = 1, `overflow` <= 0.
  - Else: `value` unchanged, `value_valid` = 0, `overflow` <= 1.
  - `busy` = 0; next state = IDLE.
- Latency: enter event in cycle N -> CONVERT in cycles N+1..N+10 -> `value_valid` in cycle N+11.
- Events during CONVERT/DONE are discarded, not queued. `bcd` and `digit_sel` are frozen.
- `bcd` is retained after conversion, so the user may edit and re-enter.
- Arithmetic: nibble adjust is 4-bit modulo; the binary field is 10 bits (maximum 999).

Decomposition:
- Shared package: state enum (IDLE, CONVERT, DONE); constants BCD_DIGITS = 3, BIN_W = 10, OUT_W = 8, CONV_ITERS = 10.
- One sub-module, `btn_debounce` (synchronizer, counter, rising-edge event output), instanced three times, parameterized by DEBOUNCE_CYCLES and CNT_W.

Test Plan (run with DEBOUNCE_CYCLES = 4):
1. Assert `rst` 3 cycles, then hold all buttons low -> `bcd` = 0, `digit_sel` = 0, `value` = 0, `value_valid` = 0, `overflow` = 0, `busy` = 0.
2. Toggle `btn_inc` every 2 cycles for 12 cycles, then hold it high 10 cycles -> `bcd` = 12'h001 (exactly one increment).
3. Enter digits 2, 5, 5, then press enter -> `busy` high for 10 cycles; `value_valid` high for 1 cycle at N+11; `value` = 8'hFF; `overflow` = 0.
4. Then set `bcd` = 256 and press enter -> no `value_valid`; `overflow` = 1; `value` stays 8'hFF. Set 042 and enter -> `value` = 8'h2A, `overflow` = 0.
5. Press inc 10 times on ones -> ones returns to 0. Press sel 3 times -> `digit_sel` = 0. Press inc and sel debounced in the same cycle -> only sel takes effect.
6. Press enter, assert `rst` at CONVERT cycle 5 -> next cycle state = IDLE, `value` = 0, `busy` = 0; no `value_valid` for the following 20 cycles.

Source files
------------

// File: rtl/bcd_entry_pkg.sv
// Shared types, constants and the reverse double-dabble step for bcd_entry.
package bcd_entry_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_e;

  localparam int BCD_DIGITS = 3;
  localparam int BIN_W      = 10;
  localparam int OUT_W      = 8;
  localparam int CONV_ITERS = 10;
  localparam int SR_W       = BCD_DIGITS * 4 + BIN_W;

  // One reverse double-dabble iteration: shift right, then pull every
  // BCD nibble that reached 8 or more back down by 3 (4-bit modulo).
  function automatic logic [SR_W-1:0] rdd_step(input logic [SR_W-1:0] sr);
    logic [SR_W-1:0] t;
    t = sr >> 1;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (t[BIN_W + 4*d + 3 -: 4] >= 4'd8)
        t[BIN_W + 4*d + 3 -: 4] = t[BIN_W + 4*d + 3 -: 4] - 4'd3;
    end
    return t;
  endfunction

endpackage

// File: rtl/bcd_entry_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter and a one-cycle
// event on each accepted press (rising edge of the stable level).
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 100_000,
  parameter int CNT_W           = 17
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic evt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic             stable_q;
  logic [CNT_W-1:0] cnt;

  // Synchronize, then accept a new level only after it has held long enough.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      cnt      <= '0;
    end else begin
      sync1    <= btn;
      sync2    <= sync1;
      stable_q <= stable;
      if (sync2 != stable) begin
        if (cnt == CNT_LAST) begin
          stable <= sync2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  // Only presses matter; releases are debounced but produce no event.
  assign evt = stable & ~stable_q;

endmodule

// File: rtl/bcd_entry.sv
// Three-button decimal entry with BCD-to-binary conversion.
// Output handshake: value_valid is a one-cycle strobe with no ready; the
// consumer must capture value (held until the next good conversion) on it.
module bcd_entry
  import bcd_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100_000,
  parameter int CNT_W           = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_inc,
  input  logic             btn_sel,
  input  logic             btn_enter,
  output logic [11:0]      bcd,
  output logic [1:0]       digit_sel,
  output logic [OUT_W-1:0] value,
  output logic             value_valid,
  output logic             overflow,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  localparam logic [3:0] ITER_LAST = 4'(CONV_ITERS - 1);

  logic inc_evt;
  logic sel_evt;
  logic enter_evt;

  state_e          state;
  state_e          state_d;
  logic [SR_W-1:0] sr;
  logic [3:0]      iter;
  logic            res_ovf;
  logic [3:0]      cur_nib;
  logic [3:0]      nxt_nib;
  logic [11:0]     bcd_inc;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_inc (
    .clk(clk), .rst(rst), .btn(btn_inc), .evt(inc_evt)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_sel (
    .clk(clk), .rst(rst), .btn(btn_sel), .evt(sel_evt)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_enter (
    .clk(clk), .rst(rst), .btn(btn_enter), .evt(enter_evt)
  );

  // Result above 255 cannot be presented on the 8-bit value bus.
  assign res_ovf = |sr[BIN_W-1:OUT_W];

  // Selected digit incremented with 9 -> 0 wrap, other digits untouched.
  always_comb begin
    cur_nib = 4'd0;
    bcd_inc = bcd;
    case (digit_sel)
      2'd0:    cur_nib = bcd[3:0];
      2'd1:    cur_nib = bcd[7:4];
      default: cur_nib = bcd[11:8];
    endcase
    nxt_nib = (cur_nib >= 4'd9) ? 4'd0 : cur_nib + 4'd1;
    case (digit_sel)
      2'd0:    bcd_inc[3:0]  = nxt_nib;
      2'd1:    bcd_inc[7:4]  = nxt_nib;
      default: bcd_inc[11:8] = nxt_nib;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next state and the status strobes that depend only on state.
  always_comb begin
    state_d     = state;
    busy        = 1'b0;
    value_valid = 1'b0;
    case (state)
      IDLE:    if (enter_evt) state_d = CONVERT;
      CONVERT: begin
        busy = 1'b1;
        if (iter == ITER_LAST) state_d = DONE;
      end
      DONE: begin
        value_valid = ~res_ovf;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign state_dbg = state;

  // Digit editing in IDLE (enter > sel > inc), conversion and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd       <= '0;
      digit_sel <= '0;
      sr        <= '0;
      iter      <= '0;
      value     <= '0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enter_evt) begin
            sr   <= {bcd, {BIN_W{1'b0}}};
            iter <= '0;
          end else if (sel_evt) begin
            digit_sel <= (digit_sel == 2'd2) ? 2'd0 : digit_sel + 2'd1;
          end else if (inc_evt) begin
            bcd <= bcd_inc;
          end
        end
        CONVERT: begin
          sr   <= rdd_step(sr);
          iter <= iter + 4'd1;
        end
        DONE: begin
          if (!res_ovf) value <= sr[OUT_W-1:0];
          overflow <= res_ovf;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_entry.sv
// Bench for bcd_entry with a short debounce window.
module tb_bcd_entry;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_inc;
  logic        btn_sel;
  logic        btn_enter;
  logic [11:0] bcd;
  logic [1:0]  digit_sel;
  logic [7:0]  value;
  logic        value_valid;
  logic        overflow;
  logic        busy;
  logic [1:0]  state_dbg;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  bcd_entry #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .btn_inc(btn_inc), .btn_sel(btn_sel),
    .btn_enter(btn_enter), .bcd(bcd), .digit_sel(digit_sel), .value(value),
    .value_valid(value_valid), .overflow(overflow), .busy(busy),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the number the user has keyed in, as decimal digits.
  int m_dig[3];
  int m_sel;
  int m_value;
  int m_ovf;
  logic [11:0] exp_q[$];

  // Observers of the strobes.
  int   vv_cnt = 0;
  int   vv_wide = 0;
  logic vv_prev = 1'b0;
  int   busy_run = 0;
  int   last_busy_len = 0;
  int   vv_after_busy = 0;

  always @(negedge clk) begin
    if (value_valid) vv_cnt++;
    if (value_valid && vv_prev) vv_wide++;
    vv_prev = value_valid;
    if (busy) busy_run++;
    else if (busy_run != 0) begin
      last_busy_len = busy_run;
      vv_after_busy = int'(value_valid);
      busy_run = 0;
    end
  end

  typedef struct {
    int h; int t; int o;
    int exp_value; int exp_ovf; int exp_vv;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [11:0] model_bcd();
    return 12'(m_dig[2] * 256 + m_dig[1] * 16 + m_dig[0]);
  endfunction

  function automatic void model_reset();
    m_dig[0] = 0; m_dig[1] = 0; m_dig[2] = 0;
    m_sel = 0; m_value = 0; m_ovf = 0;
  endfunction

  function automatic void model_event(input int which);
    int n;
    if (which == 0) m_dig[m_sel] = (m_dig[m_sel] + 1) % 10;
    else if (which == 1) m_sel = (m_sel + 1) % 3;
    else begin
      n = 100 * m_dig[2] + 10 * m_dig[1] + m_dig[0];
      if (n <= 255) begin m_value = n; m_ovf = 0; end
      else m_ovf = 1;
    end
  endfunction

  // ---------------- driver tasks ----------------
  // which: 0 = inc, 1 = sel, 2 = enter
  task automatic press(input int which);
    if (which == 0) btn_inc = 1'b1;
    else if (which == 1) btn_sel = 1'b1;
    else btn_enter = 1'b1;
    cyc(10);
    btn_inc = 1'b0; btn_sel = 1'b0; btn_enter = 1'b0;
    cyc(10);
    if (which == 2) cyc(12);
    model_event(which);
  endtask

  task automatic set_number(input int h, input int t, input int o);
    int tgt[3];
    int k;
    tgt[0] = o; tgt[1] = t; tgt[2] = h;
    for (int d = 0; d < 3; d++) begin
      while (m_sel != d) press(1);
      k = (tgt[d] - m_dig[d] + 10) % 10;
      repeat (k) press(0);
    end
  endtask

  task automatic check_entry(input string tag);
    check({tag, "_bcd"}, int'(bcd), int'(model_bcd()));
    check({tag, "_sel"}, int'(digit_sel), m_sel);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int v0;
    int n;
    int start_sel;
    logic [11:0] saved;
    bit seen;
    model_reset();

    // 1. reset state
    rst = 1'b1; btn_inc = 1'b0; btn_sel = 1'b0; btn_enter = 1'b0;
    cyc(3);
    rst = 1'b0;
    cyc(1);
    check("rst_bcd", int'(bcd), 0);
    check("rst_digit_sel", int'(digit_sel), 0);
    check("rst_value", int'(value), 0);
    check("rst_value_valid", int'(value_valid), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_state", int'(state_dbg), 0);

    // 2. bouncing inc, then a clean hold: exactly one increment
    for (int i = 0; i < 6; i++) begin
      btn_inc = ~btn_inc;
      cyc(2);
    end
    btn_inc = 1'b1;
    cyc(10);
    check("bounce_one_inc", int'(bcd), 12'h001);
    btn_inc = 1'b0;
    cyc(10);
    check("bounce_release", int'(bcd), 12'h001);
    m_dig[0] = 1;

    // 3/4. table of entries, including 255, 256, 042 boundary cases
    vecs[0] = '{2, 5, 5, 255, 0, 1};
    vecs[1] = '{2, 5, 6, 255, 1, 0};
    vecs[2] = '{0, 4, 2, 42,  0, 1};
    vecs[3] = '{9, 9, 9, 42,  1, 0};
    vecs[4] = '{0, 0, 0, 0,   0, 1};
    vecs[5] = '{1, 2, 8, 128, 0, 1};
    vecs[6] = '{3, 0, 0, 128, 1, 0};
    vecs[7] = '{1, 0, 0, 100, 0, 1};
    for (int i = 0; i < 8; i++) begin
      set_number(vecs[i].h, vecs[i].t, vecs[i].o);
      check_entry($sformatf("vec%0d_pre", i));
      v0 = vv_cnt;
      press(2);
      check($sformatf("vec%0d_value", i), int'(value), vecs[i].exp_value);
      check($sformatf("vec%0d_overflow", i), int'(overflow), vecs[i].exp_ovf);
      check($sformatf("vec%0d_vv_count", i), vv_cnt - v0, vecs[i].exp_vv);
      check($sformatf("vec%0d_busy_len", i), last_busy_len, 10);
      check($sformatf("vec%0d_vv_after_busy", i), vv_after_busy, vecs[i].exp_vv);
      check($sformatf("vec%0d_bcd_kept", i), int'(bcd),
            vecs[i].h * 256 + vecs[i].t * 16 + vecs[i].o);
    end
    check("vv_single_cycle", vv_wide, 0);

    // 5. wrap of ones, wrap of selection, simultaneous inc+sel
    while (m_sel != 0) press(1);
    saved = bcd;
    repeat (10) press(0);
    check("ones_wrap", int'(bcd), int'(saved));
    start_sel = int'(digit_sel);
    repeat (3) press(1);
    check("sel_wrap", int'(digit_sel), start_sel);
    btn_inc = 1'b1; btn_sel = 1'b1;
    cyc(10);
    btn_inc = 1'b0; btn_sel = 1'b0;
    cyc(10);
    m_sel = (m_sel + 1) % 3;
    check("simul_sel_wins", int'(digit_sel), m_sel);
    check("simul_inc_dropped", int'(bcd), int'(saved));

    // randomized entries against the decimal model
    for (int i = 0; i < 6; i++) begin
      set_number($urandom_range(0, 3), $urandom_range(0, 9), $urandom_range(0, 9));
      n = 100 * m_dig[2] + 10 * m_dig[1] + m_dig[0];
      exp_q.push_back(model_bcd());
      check_entry($sformatf("rnd%0d_pre", i));
      v0 = vv_cnt;
      press(2);
      check($sformatf("rnd%0d_value", i), int'(value), m_value);
      check($sformatf("rnd%0d_overflow", i), int'(overflow), m_ovf);
      check($sformatf("rnd%0d_vv_count", i), vv_cnt - v0, (n <= 255) ? 1 : 0);
      check($sformatf("rnd%0d_bcd_kept", i), int'(bcd), int'(exp_q.pop_front()));
    end

    // 6. reset in the middle of a conversion
    btn_enter = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    check("abort_busy_seen", int'(seen), 1);
    cyc(4);
    rst = 1'b1;
    btn_enter = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    v0 = vv_cnt;
    check("abort_state_idle", int'(state_dbg), 0);
    check("abort_value", int'(value), m_value);
    check("abort_busy", int'(busy), 0);
    check("abort_bcd", int'(bcd), int'(model_bcd()));
    cyc(20);
    check("abort_no_vv", vv_cnt - v0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard bound in case something stalls.
  initial begin
    #900000;
    $display("FAIL timeout: got no_finish expected finish");
    $fatal(1, "bench timeout");
  end

endmodule
